mag_pingpong_buffer: RTL and testbench
======================================

MAG_PINGPONG_BUFFER -- requirements
Module: mag_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter NBINS, default 32, the number of magnitude bins per frame.
REQ-002 The block SHALL have parameter BIN_W, default 16, the magnitude bin width.
REQ-003 The block SHALL have parameter DROP_ON_FULL, default 0: 0 = back-pressure the writer, 1 = discard the frame.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port list SHALL be:
  clk         in   1      clock
  rst_n       in   1      asynchronous active-low reset
  s_valid     in   1      input bin valid (from FFT magnitude stage)
  s_ready     out  1      input bin accepted when s_valid && s_ready
  s_data      in   BIN_W  magnitude bin value
  s_last      in   1      marks final bin of frame
  fx_start    out  1      one-cycle start pulse to feature extractor
  fx_busy     in   1      feature extractor busy
  fx_done     in   1      feature extractor done pulse; releases read bank
  mag_addr    in   5      read bin address from extractor
  mag_data    out  BIN_W  registered read data
  frame_err   out  1      one-cycle framing-error pulse
  drop_cnt    out  8      saturating count of discarded frames

Function
REQ-006 Storage SHALL be two banks of NBINS x BIN_W; the write bank (wr_bank) and the read bank (~wr_bank) are never the same bank.
REQ-007 The write counter wr_idx SHALL start at 0 and store each accepted beat at mem[wr_bank][wr_idx], then increment.
REQ-008 The writer FSM SHALL have states W_FILL (s_ready=1) and W_HOLD (s_ready=0).
REQ-009 A frame SHALL be complete on the beat accepted with wr_idx==NBINS-1.
REQ-010 The read side SHALL have flag rd_full, set on swap and cleared on fx_done.
REQ-011 On frame completion with rd_full==0 and fx_busy==0, the block SHALL do the following on the next cycle: toggle wr_bank, set rd_full, pulse fx_start for exactly 1 cycle, reset wr_idx to 0, and remain in W_FILL.
REQ-012 On frame completion with rd_full==1 or fx_busy==1 and DROP_ON_FULL==0, the block SHALL enter W_HOLD.
REQ-013 The block SHALL leave W_HOLD by performing the swap of REQ-011 on the first cycle where rd_full==0 and fx_busy==0.
REQ-014 When fx_done coincides with frame completion, the swap SHALL occur on the next cycle and no bin SHALL be lost.
REQ-015 On frame completion with rd_full==1 or fx_busy==1 and DROP_ON_FULL==1, the block SHALL discard the frame, reset wr_idx to 0, increment drop_cnt (saturating at 255), and keep s_ready=1.
REQ-016 Beat with s_last=1 and wr_idx!=NBINS-1: the block SHALL discard the partial frame, reset wr_idx to 0, pulse frame_err, and perform no swap.
REQ-017 Beat with wr_idx==NBINS-1 and s_last=0: the block SHALL treat the frame as complete and pulse frame_err.
REQ-018 The read port SHALL register mag_data <= mem[read bank][mag_addr] every cycle, giving 1-cycle latency.
REQ-019 The read bank contents SHALL remain stable while rd_full==1.
REQ-020 An fx_done received while rd_full==0 SHALL be ignored.

Reset
REQ-021 While rst_n==0, the block SHALL force: s_ready=1, fx_start=0, mag_data=0, frame_err=0, drop_cnt=0, wr_bank=0, wr_idx=0, rd_full=0, writer FSM=W_FILL.
REQ-022 Reset mid-frame or mid-read SHALL discard all buffered frames.
REQ-023 Memory contents SHALL NOT be reset.

Structure
REQ-024 NBINS, BIN_W and the address width SHALL live in shared package senseedge_pkg, also used by the FFT magnitude stage and feature_extract.
REQ-025 Storage SHALL be one sub-module, mag_bank_ram: 2x32x16, one write port, one registered read port, bank select on each port.

Verification
REQ-026 Write 32 beats s_data=i*16, s_last on beat 31, with fx idle -> exactly one fx_start pulse 1 cycle after beat 31; reading mag_addr=7 -> mag_data=0x0070 the following cycle.
REQ-027 Second frame completes while rd_full=1, DROP_ON_FULL=0 -> s_ready=0 until fx_done; swap 1 cycle after fx_done; second frame read back intact.
REQ-028 Same as REQ-027 with DROP_ON_FULL=1 -> s_ready stays 1, drop_cnt=1, no fx_start; 256 drops -> drop_cnt holds at 255.
REQ-029 s_last on beat 10 -> frame_err pulse, no fx_start; next full 32-beat frame -> normal swap.
REQ-030 fx_done in the same cycle as beat 31 of the next frame -> fx_start 1 cycle later, all 32 bins correct.
REQ-031 rst_n pulsed low during beat 20 -> all outputs at reset values immediately, no fx_start until a new full frame is written.

Source files
------------

// File: rtl/senseedge_pkg.sv
// Shared sizing for the spectral front end (FFT magnitude stage, ping-pong buffer, feature extractor).
package senseedge_pkg;

    localparam int SE_NBINS = 32;
    localparam int SE_BIN_W = 16;
    localparam int ADDR_W   = 5;

    typedef enum logic {
        W_FILL = 1'b0,
        W_HOLD = 1'b1
    } wr_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mag_bank_ram.sv
// Two-bank magnitude store: one write port, one registered read port, bank select on each.
module mag_bank_ram
    import senseedge_pkg::*;
#(
    parameter int NBINS = SE_NBINS,
    parameter int BIN_W = SE_BIN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BIN_W-1:0]  i_wr_data,
    input  logic              i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [BIN_W-1:0]  o_rd_data
);

    logic [BIN_W-1:0] r_mem [0:1][0:NBINS-1];
    logic [BIN_W-1:0] r_rd_data;

    // Array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mag_pingpong_buffer.sv
// Ping-pong buffer between the FFT magnitude stream and the feature extractor.
module mag_pingpong_buffer
    import senseedge_pkg::*;
#(
    parameter int NBINS        = SE_NBINS,
    parameter int BIN_W        = SE_BIN_W,
    parameter int DROP_ON_FULL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BIN_W-1:0]  s_data,
    input  logic              s_last,
    output logic              fx_start,
    input  logic              fx_busy,
    input  logic              fx_done,
    input  logic [ADDR_W-1:0] mag_addr,
    output logic [BIN_W-1:0]  mag_data,
    output logic              frame_err,
    output logic [7:0]        drop_cnt
);

    wr_state_e         r_state;
    logic              r_s_ready;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_idx;
    logic              r_rd_full;
    logic              r_fx_start;
    logic              r_frame_err;
    logic [7:0]        r_drop_cnt;

    logic w_accept;
    logic w_last_idx;
    logic w_rd_avail;

    assign w_accept   = s_valid & r_s_ready;
    assign w_last_idx = (r_wr_idx == ADDR_W'(NBINS - 1));
    // A done pulse in the completion cycle frees the read bank for an immediate swap.
    assign w_rd_avail = (~r_rd_full | fx_done) & ~fx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= W_FILL;
            r_s_ready   <= 1'b1;
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_full   <= 1'b0;
            r_fx_start  <= 1'b0;
            r_frame_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_fx_start  <= 1'b0;
            r_frame_err <= w_accept & (s_last ^ w_last_idx);
            if (fx_done && r_rd_full)
                r_rd_full <= 1'b0;
            case (r_state)
                W_FILL: begin
                    if (w_accept) begin
                        if (!w_last_idx) begin
                            r_wr_idx <= s_last ? '0 : r_wr_idx + ADDR_W'(1);
                        end else if (w_rd_avail) begin
                            r_wr_bank  <= ~r_wr_bank;
                            r_rd_full  <= 1'b1;
                            r_fx_start <= 1'b1;
                            r_wr_idx   <= '0;
                        end else if (DROP_ON_FULL != 0) begin
                            r_wr_idx   <= '0;
                            r_drop_cnt <= sat_inc8(r_drop_cnt);
                        end else begin
                            r_state   <= W_HOLD;
                            r_s_ready <= 1'b0;
                        end
                    end
                end
                W_HOLD: begin
                    if (w_rd_avail) begin
                        r_wr_bank  <= ~r_wr_bank;
                        r_rd_full  <= 1'b1;
                        r_fx_start <= 1'b1;
                        r_wr_idx   <= '0;
                        r_state    <= W_FILL;
                        r_s_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    mag_bank_ram #(
        .NBINS (NBINS),
        .BIN_W (BIN_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (s_data),
        .i_rd_bank (~r_wr_bank),
        .i_rd_addr (mag_addr),
        .o_rd_data (mag_data)
    );

    assign s_ready   = r_s_ready;
    assign fx_start  = r_fx_start;
    assign frame_err = r_frame_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mag_pingpong_buffer.sv
// Scenario bench: dut0 back-pressures, dut1 drops; both share the stimulus.
module tb_mag_pingpong_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        fx_busy = 1'b0;
    logic        fx_done = 1'b0;
    logic [4:0]  mag_addr = '0;

    logic        rdy0, fxs0, ferr0, rdy1, fxs1, ferr1;
    logic [15:0] md0, md1;
    logic [7:0]  dc0, dc1;

    int checks = 0;
    int errors = 0;
    int n_fx0 = 0;
    int n_fx1 = 0;

    logic [15:0] sent [32];
    logic [15:0] ref_rd [32];
    logic [15:0] rd0 [32];
    logic [15:0] rd1 [32];

    always #5 clk = ~clk;

    mag_pingpong_buffer #(.NBINS(32), .BIN_W(16), .DROP_ON_FULL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
        .s_last(s_last), .fx_start(fxs0), .fx_busy(fx_busy), .fx_done(fx_done),
        .mag_addr(mag_addr), .mag_data(md0), .frame_err(ferr0), .drop_cnt(dc0));

    mag_pingpong_buffer #(.NBINS(32), .BIN_W(16), .DROP_ON_FULL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
        .s_last(s_last), .fx_start(fxs1), .fx_busy(fx_busy), .fx_done(fx_done),
        .mag_addr(mag_addr), .mag_data(md1), .frame_err(ferr1), .drop_cnt(dc1));

    always @(negedge clk) begin
        if (fxs0) n_fx0++;
        if (fxs1) n_fx1++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_valid = 0; s_last = 0; fx_done = 0; fx_busy = 0; mag_addr = '0;
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        step();
    endtask

    // Streams n beats at frame positions base..base+n-1; s_last where position == last_at.
    task automatic send(input int n, input int last_at, input bit ramp, input int base);
        for (int i = base; i < base + n; i++) begin
            s_valid = 1;
            s_data  = ramp ? 16'(i * 16) : 16'($urandom);
            s_last  = (i == last_at);
            sent[i] = s_data;
            step();
        end
        s_valid = 0; s_last = 0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            mag_addr = 5'(a);
            step();
            rd0[a] = md0;
            rd1[a] = md1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", rdy0); end
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL reset_fx_start got %b exp 0", fxs0); end
        checks++; if (md0 !== 16'h0) begin errors++; $display("FAIL reset_mag_data got %h exp 0", md0); end
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", ferr0); end
        checks++; if (dc1 !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", dc1); end
    endtask

    task automatic test_basic();
        int base;
        base = n_fx0;
        send(32, 31, 1'b1, 0);
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL basic_fx_start got %b exp 1", fxs0); end
        step();
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL basic_fx_start_width got %b exp 0", fxs0); end
        checks++; if (n_fx0 - base !== 1) begin errors++; $display("FAIL basic_pulse_count got %0d exp 1", n_fx0 - base); end
        mag_addr = 5'd7;
        step();
        checks++; if (md0 !== 16'h0070) begin errors++; $display("FAIL basic_read7 got %h exp 0070", md0); end
    endtask

    task automatic test_backpressure();
        send(32, 31, 1'b0, 0);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_hold got %b exp 0", rdy0); end
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL bp_no_start got %b exp 0", fxs0); end
        mag_addr = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_hold_wait got %b exp 0", rdy0); end
        end
        checks++; if (md0 !== 16'h0070) begin errors++; $display("FAIL bp_read_stable got %h exp 0070", md0); end
        ref_rd = sent;
        fx_done = 1;
        step();
        fx_done = 0;
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL bp_swap_start got %b exp 1", fxs0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", rdy0); end
        read_all();
        for (int a = 0; a < 32; a++) begin
            checks++; if (rd0[a] !== ref_rd[a]) begin errors++; $display("FAIL bp_bin%0d got %h exp %h", a, rd0[a], ref_rd[a]); end
        end
    endtask

    task automatic test_drop();
        int base;
        do_reset();
        base = n_fx1;
        send(32, 31, 1'b0, 0);
        ref_rd = sent;
        send(32, 31, 1'b0, 0);
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL drop_ready got %b exp 1", rdy1); end
        checks++; if (dc1 !== 8'd1) begin errors++; $display("FAIL drop_cnt1 got %0d exp 1", dc1); end
        checks++; if (n_fx1 - base !== 1) begin errors++; $display("FAIL drop_no_start got %0d exp 1", n_fx1 - base); end
        read_all();
        for (int a = 0; a < 32; a += 5) begin
            checks++; if (rd1[a] !== ref_rd[a]) begin errors++; $display("FAIL drop_bin%0d got %h exp %h", a, rd1[a], ref_rd[a]); end
        end
        for (int f = 0; f < 254; f++) send(32, 31, 1'b0, 0);
        checks++; if (dc1 !== 8'd255) begin errors++; $display("FAIL drop_cnt255 got %0d exp 255", dc1); end
        send(32, 31, 1'b0, 0);
        checks++; if (dc1 !== 8'd255) begin errors++; $display("FAIL drop_cnt_sat got %0d exp 255", dc1); end
    endtask

    task automatic test_framing();
        do_reset();
        send(11, 10, 1'b0, 0);
        checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", ferr0); end
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL short_no_start got %b exp 0", fxs0); end
        step();
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL short_err_width got %b exp 0", ferr0); end
        send(32, 31, 1'b0, 0);
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL after_short_start got %b exp 1", fxs0); end
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL after_short_err got %b exp 0", ferr0); end
        ref_rd = sent;
        read_all();
        for (int a = 0; a < 32; a++) begin
            checks++; if (rd0[a] !== ref_rd[a]) begin errors++; $display("FAIL frm_bin%0d got %h exp %h", a, rd0[a], ref_rd[a]); end
        end
        fx_done = 1;
        step();
        fx_done = 0;
        send(32, -1, 1'b0, 0);
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL nolast_start got %b exp 1", fxs0); end
        checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL nolast_err got %b exp 1", ferr0); end
    endtask

    task automatic test_done_coincide();
        do_reset();
        send(32, 31, 1'b0, 0);
        send(31, 31, 1'b0, 0);
        s_valid = 1; s_last = 1; s_data = 16'($urandom); sent[31] = s_data; fx_done = 1;
        step();
        s_valid = 0; s_last = 0; fx_done = 0;
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL coin_start got %b exp 1", fxs0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL coin_ready got %b exp 1", rdy0); end
        ref_rd = sent;
        read_all();
        for (int a = 0; a < 32; a++) begin
            checks++; if (rd0[a] !== ref_rd[a]) begin errors++; $display("FAIL coin_bin%0d got %h exp %h", a, rd0[a], ref_rd[a]); end
        end
    endtask

    task automatic test_busy();
        do_reset();
        fx_busy = 1;
        send(32, 31, 1'b0, 0);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL busy_hold got %b exp 0", rdy0); end
        repeat (3) step();
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL busy_no_start got %b exp 0", fxs0); end
        fx_busy = 0;
        step();
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL busy_release_start got %b exp 1", fxs0); end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        send(32, 31, 1'b0, 0);
        send(20, 31, 1'b0, 0);
        s_valid = 1; s_data = 16'($urandom);
        #3 rst_n = 0;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rmid_s_ready got %b exp 1", rdy0); end
        checks++; if (fxs0 !== 1'b0) begin errors++; $display("FAIL rmid_fx_start got %b exp 0", fxs0); end
        checks++; if (md0 !== 16'h0) begin errors++; $display("FAIL rmid_mag_data got %h exp 0", md0); end
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL rmid_frame_err got %b exp 0", ferr0); end
        s_valid = 0;
        step();
        rst_n = 1;
        step();
        base = n_fx0;
        send(31, 31, 1'b0, 0);
        step();
        checks++; if (n_fx0 - base !== 0) begin errors++; $display("FAIL rmid_early_start got %0d exp 0", n_fx0 - base); end
        send(1, 31, 1'b0, 31);
        checks++; if (fxs0 !== 1'b1) begin errors++; $display("FAIL rmid_new_start got %b exp 1", fxs0); end
        ref_rd = sent;
        read_all();
        for (int a = 0; a < 32; a += 3) begin
            checks++; if (rd0[a] !== ref_rd[a]) begin errors++; $display("FAIL rmid_bin%0d got %h exp %h", a, rd0[a], ref_rd[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_framing();
        test_done_coincide();
        test_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
